// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage: registers the 4-bit ALU code and holds it for the op's settle time before raising out_valid.
// Optional illegal-op detection is built only when ALU_ILLEGAL_DET_EN is defined; otherwise illegal is tied to 0.
module alu_issue_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       multicycle,
    output logic       illegal
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [3:0] CODE_ADD  = 4'b0010;
    localparam logic [3:0] CODE_MULT = 4'b0101;
    localparam logic [3:0] CODE_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        VALID  = 2'b10
    } state_t;

    function automatic logic [3:0] decode_code(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] code;
        code = CODE_ADD;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: code = 4'b0010;
                6'h22, 6'h23: code = 4'b0110;
                6'h24:        code = 4'b0000;
                6'h25:        code = 4'b0001;
                6'h26:        code = 4'b0100;
                6'h27:        code = 4'b1100;
                6'h2A:        code = 4'b0111;
                6'h00:        code = 4'b1000;
                6'h02:        code = 4'b1001;
                6'h03:        code = 4'b1010;
                6'h18:        code = CODE_MULT;
                6'h1A:        code = CODE_DIV;
                default:      code = CODE_ADD;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h23, 6'h2B: code = 4'b0010;
                6'h0C:                      code = 4'b0000;
                6'h0D:                      code = 4'b0001;
                6'h0E:                      code = 4'b0100;
                6'h0A:                      code = 4'b0111;
                6'h04, 6'h05:               code = 4'b0110;
                6'h02, 6'h03:               code = 4'b0010;
                default:                    code = CODE_ADD;
            endcase
        end
        return code;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] load_cnt_s;
    logic [3:0]       code_s;
    logic             mc_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       alu_control_r;
    logic             out_valid_r;
    logic             multicycle_r;

    // Decode the presented op and pick its settle-counter preload
    always_comb begin
        code_s = decode_code(opcode, funct);
        mc_s   = (code_s == CODE_MULT) || (code_s == CODE_DIV);
        if (code_s == CODE_MULT) begin
            load_cnt_s = MULT_LOAD;
        end else if (code_s == CODE_DIV) begin
            load_cnt_s = DIV_LOAD;
        end else begin
            load_cnt_s = CNT_ZERO;
        end
    end

    // Upstream handshake: ready in IDLE, or in VALID when downstream consumes
    always_comb begin
        in_ready_s = 1'b0;
        if (rst_n) begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                VALID:   in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Next-state and settle-counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_nxt_s   = load_cnt_s;
                    state_nxt_s = (load_cnt_s != CNT_ZERO) ? SETTLE : VALID;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                // Saturating decrement; a zero count here is unreachable but still exits safely
                cnt_nxt_s   = (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
                state_nxt_s = (cnt_r <= CNT_ONE) ? VALID : SETTLE;
            end
            VALID: begin
                if (accept_s) begin
                    cnt_nxt_s   = load_cnt_s;
                    state_nxt_s = (load_cnt_s != CNT_ZERO) ? SETTLE : VALID;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = VALID;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            alu_control_r <= CODE_ADD;
            out_valid_r   <= 1'b0;
            multicycle_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (state_nxt_s == VALID);
            if (accept_s) begin
                alu_control_r <= code_s;
                multicycle_r  <= mc_s;
            end else begin
                alu_control_r <= alu_control_r;
                multicycle_r  <= multicycle_r;
            end
        end
    end

`ifdef ALU_ILLEGAL_DET_EN
    // True when the op has no entry in the decode table (falls to default add)
    function automatic logic decode_miss(input logic [5:0] op, input logic [5:0] fn);
        logic miss;
        miss = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h00, 6'h02, 6'h03, 6'h18, 6'h1A: miss = 1'b0;
                default:                                  miss = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                6'h04, 6'h05, 6'h02, 6'h03: miss = 1'b0;
                default:                    miss = 1'b1;
            endcase
        end
        return miss;
    endfunction

    logic illegal_r;

    // Illegal flag travels with the issued code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            illegal_r <= decode_miss(opcode, funct);
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    assign in_ready    = in_ready_s;
    assign alu_control = alu_control_r;
    assign out_valid   = out_valid_r;
    assign multicycle  = multicycle_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: latency/queue model compared every cycle, plus pinned directed checks.
module tb_alu_issue_ctrl;
    localparam int MC = 4;
    localparam int DC = 16;
    localparam int NV = 23;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       in_ready;
    logic [3:0] alu_control;
    logic       out_valid;
    logic       multicycle;
    logic       illegal;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .multicycle(multicycle), .illegal(illegal)
    );

    // Lookup tables: R-type by funct, others by opcode; *_known marks table entries
    logic [3:0] r_code [64];
    bit         r_known[64];
    logic [3:0] i_code [64];
    bit         i_known[64];

    // Reference model state: one op in flight with remaining cycles until valid
    bit         pend = 1'b0;
    int         rem = 0;
    logic [3:0] m_code = 4'b0010;
    logic       m_mc = 1'b0;
    logic       m_ill = 1'b0;

    function automatic bit m_ready();
        return rst_n && (!pend || (rem == 0 && out_ready));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0; rem = 0; m_code = 4'b0010; m_mc = 1'b0; m_ill = 1'b0;
        end else if (in_valid && m_ready()) begin
            bit known;
            if (opcode == 6'h00) begin
                m_code = r_code[funct]; known = r_known[funct];
            end else begin
                m_code = i_code[opcode]; known = i_known[opcode];
            end
            m_mc = (m_code == 4'b0101) || (m_code == 4'b1011);
`ifdef ALU_ILLEGAL_DET_EN
            m_ill = !known;
`else
            m_ill = 1'b0;
`endif
            pend = 1'b1;
            rem = (m_code == 4'b0101) ? MC - 1 : (m_code == 4'b1011) ? DC - 1 : 0;
        end else if (pend && rem > 0) begin
            rem--;
        end else if (pend && out_ready) begin
            pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_alu_control", alu_control, m_code);
            check("cmp_out_valid", out_valid, pend && rem == 0);
            check("cmp_in_ready", in_ready, m_ready());
            check("cmp_multicycle", multicycle, m_mc);
            check("cmp_illegal", illegal, m_ill);
        end
    end

    logic       last_ov;
    logic [3:0] last_alu;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op (called just after a rising edge) and hold it until accepted
    task automatic issue(input logic [5:0] op, input logic [5:0] fn);
        bit ok;
        int n;
        n = 0;
        opcode = op; funct = fn; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            last_ov = out_valid;
            last_alu = alu_control;
            tick();
            n++;
        end while (!ok && n < 200);
        check("accept_in_time", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    logic [5:0] op_v[NV] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h23, 6'h2B, 6'h0C,
                             6'h0D, 6'h0A, 6'h04, 6'h05, 6'h03, 6'h0F, 6'h00};
    logic [5:0] fn_v[NV] = '{6'h21, 6'h23, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
                             6'h03, 6'h1A, 6'h3F, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h18};

    initial begin
        for (int i = 0; i < 64; i++) begin
            r_code[i] = 4'b0010; r_known[i] = 1'b0;
            i_code[i] = 4'b0010; i_known[i] = 1'b0;
        end
        r_code[6'h20] = 4'b0010; r_code[6'h21] = 4'b0010; r_code[6'h22] = 4'b0110;
        r_code[6'h23] = 4'b0110; r_code[6'h24] = 4'b0000; r_code[6'h25] = 4'b0001;
        r_code[6'h26] = 4'b0100; r_code[6'h27] = 4'b1100; r_code[6'h2A] = 4'b0111;
        r_code[6'h00] = 4'b1000; r_code[6'h02] = 4'b1001; r_code[6'h03] = 4'b1010;
        r_code[6'h18] = 4'b0101; r_code[6'h1A] = 4'b1011;
        foreach (r_known[k]) r_known[k] = (k inside {'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26,
                                                     'h27, 'h2A, 'h00, 'h02, 'h03, 'h18, 'h1A});
        i_code[6'h0C] = 4'b0000; i_code[6'h0D] = 4'b0001; i_code[6'h0E] = 4'b0100;
        i_code[6'h0A] = 4'b0111; i_code[6'h04] = 4'b0110; i_code[6'h05] = 4'b0110;
        foreach (i_known[k]) i_known[k] = (k inside {'h08, 'h09, 'h23, 'h2B, 'h0C, 'h0D,
                                                     'h0E, 'h0A, 'h04, 'h05, 'h02, 'h03});

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_alu_control", alu_control, 4'b0010);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_multicycle", multicycle, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);
        tick();

        // AND: one-cycle latency
        issue(6'h00, 6'h24);
        @(negedge clk);
        check("and_code", alu_control, 4'b0000);
        check("and_valid", out_valid, 1'b1);
        check("and_in_ready", in_ready, 1'b1);
        tick();
        @(negedge clk);
        check("and_valid_drop", out_valid, 1'b0);
        tick();

        // MULT: out_valid in the 4th cycle after accept
        issue(6'h00, 6'h18);
        for (int k = 1; k <= MC; k++) begin
            @(negedge clk);
            check("mult_code", alu_control, 4'b0101);
            check("mult_mc", multicycle, 1'b1);
            check("mult_valid", out_valid, (k == MC) ? 1'b1 : 1'b0);
            check("mult_in_ready", in_ready, (k == MC) ? 1'b1 : 1'b0);
            tick();
        end

        // Back-to-back sub then addi
        issue(6'h00, 6'h22);
        issue(6'h08, 6'h00);
        check("b2b_first_valid", last_ov, 1'b1);
        check("b2b_first_code", last_alu, 4'b0110);
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_code", alu_control, 4'b0010);
        tick();

        // Backpressure on ori
        out_ready = 1'b0;
        issue(6'h0E, 6'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_code", alu_control, 4'b0100);
            check("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        tick();

        // Unsupported opcode, then jump
        issue(6'h3F, 6'h00);
        @(negedge clk);
        check("ill_code", alu_control, 4'b0010);
`ifdef ALU_ILLEGAL_DET_EN
        check("ill_flag", illegal, 1'b1);
`else
        check("ill_flag", illegal, 1'b0);
`endif
        tick();
        issue(6'h02, 6'h00);
        @(negedge clk);
        check("jump_ill_flag", illegal, 1'b0);
        tick();

        // Table sweep with intermittent backpressure
        for (int i = 0; i < NV; i++) begin
            out_ready = (i % 3) != 0;
            issue(op_v[i], fn_v[i]);
            tick();
            out_ready = 1'b1;
        end
        repeat (DC + 2) tick();

        // Reset in the middle of a div's settle period
        issue(6'h00, 6'h1A);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_code", alu_control, 4'b0010);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_mc", multicycle, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1'b1);
        check("postrst_valid", out_valid, 1'b0);
        repeat (DC + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
